// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - two-domain round-robin front end for a shared byte-level I2C master core
// Each domain may only reach its own slave; other addresses are refused without touching the bus.
module i2c_bus_arbiter #(
  parameter logic [6:0]    ADDR_D0 = 7'h10,
  parameter logic [6:0]    ADDR_D1 = 7'h20,
  parameter int            TW      = 16,
  parameter logic [TW-1:0] TIMEOUT = 16'd4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic [7:0] reg0,
  input  logic [7:0] reg1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       domain,
  output logic       m_start,
  output logic       m_rw,
  output logic [6:0] m_addr,
  output logic [7:0] m_reg,
  output logic [7:0] m_wdata,
  input  logic       m_done,
  input  logic       m_ack_err,
  input  logic [7:0] m_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_DENY, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last;
  logic            r_owner;
  logic            r_rw;
  logic            r_ack_err;
  logic            r_tmo;
  logic            r_domain;
  logic [6:0]      r_addr;
  logic [7:0]      r_reg_idx;
  logic [7:0]      r_wdata;
  logic [7:0]      r_rdata0;
  logic [7:0]      r_rdata1;
  logic [TW-1:0]   r_cnt;

  logic            w_any;
  logic            w_sel;
  logic            w_legal;
  logic            w_expire;
  logic            w_done;
  logic            w_err;
  logic [TW-1:0]   w_cnt_next;

  always_comb begin
    w_any      = req0 | req1;
    w_sel      = (req0 & req1) ? ~r_last : req1;
    w_legal    = w_sel ? (addr1 == ADDR_D1) : (addr0 == ADDR_D0);
    w_cnt_next = r_cnt + 1'b1;
    // a completion landing on the expiry cycle still counts as a normal finish
    w_expire   = (w_cnt_next == TIMEOUT) && !m_done;
    w_next     = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = w_legal ? S_ISSUE : S_DENY;
      S_DENY:  w_next = S_IDLE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (m_done || w_expire) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_done = (r_state == S_DENY) || (r_state == S_RESP);
    w_err  = (r_state == S_DENY) || r_ack_err || r_tmo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_rw      <= 1'b0;
      r_ack_err <= 1'b0;
      r_tmo     <= 1'b0;
      r_domain  <= 1'b0;
      r_addr    <= '0;
      r_reg_idx <= '0;
      r_wdata   <= '0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner   <= w_sel;
            r_rw      <= w_sel ? ~we1 : ~we0;
            r_addr    <= w_sel ? addr1 : addr0;
            r_reg_idx <= w_sel ? reg1 : reg0;
            r_wdata   <= w_sel ? wdata1 : wdata0;
            r_cnt     <= '0;
            r_ack_err <= 1'b0;
            r_tmo     <= 1'b0;
            // domain switches only for granted traffic, ahead of the start strobe
            if (w_legal) r_domain <= w_sel;
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_next;
          if (m_done) begin
            r_ack_err <= m_ack_err;
            if (r_rw && !m_ack_err) begin
              if (r_owner) r_rdata1 <= m_rdata;
              else         r_rdata0 <= m_rdata;
            end
          end else if (w_expire) begin
            r_tmo <= 1'b1;
          end
        end
        S_DENY, S_RESP: r_last <= r_owner;
        default: ;
      endcase
    end
  end

  assign done0   = w_done & ~r_owner;
  assign done1   = w_done &  r_owner;
  assign err0    = w_done & w_err & ~r_owner;
  assign err1    = w_done & w_err &  r_owner;
  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;
  assign domain  = r_domain;
  assign m_start = (r_state == S_ISSUE);
  assign m_rw    = r_rw;
  assign m_addr  = r_addr;
  assign m_reg   = r_reg_idx;
  assign m_wdata = r_wdata;

endmodule

// File: doc/i2c_bus_arbiter.md
Name: i2c_bus_arbiter

Overview:
- Shares one byte-level I2C master core between two requesters, one per security domain (0 and 1).
- Round-robin arbitration; one transaction in flight at a time.
- Drives the domain select seen by the slaves and holds it constant for the whole transaction.
- Enforces an address policy: each domain may only address its own slave. Requests to any other address are rejected with no bus activity.

Parameters:
- ADDR_D0, 7'h10, only slave address domain 0 may access
- ADDR_D1, 7'h20, only slave address domain 1 may access
- TIMEOUT, 16'd4095, clk cycles allowed in WAIT before abort
- TW, 16, timeout counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req0/req1  in  1  request level; held until matching done pulse
- we0/we1  in  1  1 = write, 0 = read
- addr0/addr1  in  7  target slave address
- reg0/reg1  in  8  slave register index
- wdata0/wdata1  in  8  write data
- done0/done1  out  1  one-cycle completion pulse
- err0/err1  out  1  valid with done; 1 = denied, NACK or timeout
- rdata0/rdata1  out  8  read data; valid with done, held until next done to the same requester
- domain  out  1  owner of the bus transaction
- m_start  out  1  one-cycle command strobe to the master core
- m_rw  out  1  1 = read
- m_addr  out  7  address to the master core
- m_reg  out  8  register index to the master core
- m_wdata  out  8  write data to the master core
- m_done  in  1  master transaction complete (pulse)
- m_ack_err  in  1  NACK seen; valid with m_done
- m_rdata  in  8  read byte; valid with m_done

Behaviour:
- Reset (async, immediate) values:
  - all outputs 0; state = IDLE; last_grant = 1, so requester 0 wins first.
  - Reset mid-transaction drops the transaction: no done is issued and m_start stays 0. The master core is reset separately by the same rst.
- States: IDLE, DENY, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one req is high, select it.
  - If both are high, select the one != last_grant.
  - On selection at edge N, latch we, addr, reg, wdata and owner.
  - If the owner's latched addr != its ADDR_Dx, go to DENY; otherwise go to ISSUE.
- DENY (1 cycle):
  - done_owner = 1, err_owner = 1; rdata unchanged.
  - m_start stays 0 and domain is unchanged.
  - last_grant = owner, then return to IDLE.
- ISSUE (1 cycle):
  - domain = owner, registered at entry, so it is valid no later than m_start.
  - m_start = 1, with m_rw = ~we and m_addr/m_reg/m_wdata taken from the latched fields; go to WAIT.
  - Earliest m_start is cycle N+1.
- WAIT:
  - Counter starts at 0 and increments each cycle; m_* fields stay stable.
  - m_done = 1: capture m_rdata and m_ack_err, go to RESP.
  - Counter reaches TIMEOUT with no m_done: set a timeout flag, go to RESP.
  - m_done on the same cycle the counter reaches TIMEOUT: m_done wins and the timeout flag is not set.
- RESP (1 cycle):
  - done_owner = 1.
  - err_owner = ack_err | timeout.
  - rdata_owner = captured byte on a read without error; otherwise unchanged.
  - last_grant = owner, then go to IDLE.
  - domain holds its value after the transaction until the next ISSUE.
- Requester rules:
  - Deasserting req while owning the bus does not abort the transaction; done is still pulsed.
  - A req still high in the cycle after done starts a new arbitration.
  - Stray m_done outside WAIT is ignored.
- Minimum spacing between transactions: IDLE → ISSUE → WAIT(≥1) → RESP → IDLE, i.e. ≥4 cycles per granted transaction.
- Counter does not wrap: TW must hold TIMEOUT.

Test Plan:
- Single read: req0 with we0=0, addr0=7'h10, reg0=8'h04; model returns m_rdata=8'h12 after 20 cycles → m_start at N+1 with domain=0, m_rw=1, m_addr=10, m_reg=04; done0 with err0=0, rdata0=8'h12; done1 stays 0.
- Simultaneous requests: req0 and req1 high together, both legal addresses → requester 0 served first, then requester 1 (domain=1, m_addr=20). Then keep both high for 4 transactions → grants alternate 0,1,0,1.
- Policy violation: req1 with addr1=7'h10 → done1=1, err1=1 at N+1; m_start never asserts; domain unchanged. A following req0 is granted next.
- NACK: master model returns m_ack_err=1 on a write to 7'h20 from requester 1 → done1 with err1=1; rdata1 unchanged.
- Timeout: TIMEOUT=16'd10 and no m_done → done0 with err0=1 exactly 11 cycles after m_start. Also check m_done arriving exactly at count 10 → err0=0.
- Reset in WAIT: assert rst mid-WAIT → all outputs 0 immediately; no done issued. After release, req1 alone → granted normally; req0 wins a later tie.
